// File: rtl/icetap_capture.sv
// Purpose : icetap capture engine. Evaluates trigger/store conditions on the probed
//           signals and writes qualified samples into a circular sample RAM.
// Latency : signals_in -> s1 in 1 cycle -> registered RAM write 1 cycle later.
//           A command pulse takes effect one cycle after it is sampled.
// Backpressure: none. The RAM accepts one write per cycle, and samples are never stalled.
//
// Ports:
//   clk, reset_        capture clock; asynchronous active-high reset
//   signals_in         probed signals (NR_SIGNALS wide, synchronous to clk)
//   store_mask         3-bit store condition code per signal (latched on start)
//   trigger_mask       3-bit trigger condition code per signal (latched on start)
//   post_trig_cnt      number of samples stored after the trigger sample
//   cmd, cmd_valid     {force, abort, start} command and its single-cycle strobe
//   mem_wr/addr/wdata  sample RAM write port (registered)
//   state              0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   trigger_addr       RAM address holding the trigger sample
//   wrapped            write pointer has wrapped since the last start
module icetap_capture #(
  parameter int NR_SIGNALS = 16,
  parameter int ADDR_BITS  = 8
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic [NR_SIGNALS-1:0]     signals_in,
  input  logic [3*NR_SIGNALS-1:0]   store_mask,
  input  logic [3*NR_SIGNALS-1:0]   trigger_mask,
  input  logic [ADDR_BITS-1:0]      post_trig_cnt,
  input  logic [2:0]                cmd,
  input  logic                      cmd_valid,
  output logic                      mem_wr,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [NR_SIGNALS-1:0]     mem_wdata,
  output logic [1:0]                state,
  output logic [ADDR_BITS-1:0]      trigger_addr,
  output logic                      wrapped
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Condition codes: 1 high, 2 low, 3 rising, 4 falling, 5 any edge, others don't care.
  function automatic logic cond_match(input logic [2:0] code, input logic cur, input logic prev);
    case (code)
      3'd1:    cond_match = cur;
      3'd2:    cond_match = ~cur;
      3'd3:    cond_match = cur & ~prev;
      3'd4:    cond_match = ~cur & prev;
      3'd5:    cond_match = cur ^ prev;
      default: cond_match = 1'b1;
    endcase
  endfunction

  function automatic logic cond_active(input logic [2:0] code);
    cond_active = (code >= 3'd1) && (code <= 3'd5);
  endfunction

  // Sample pipeline and latched configuration
  logic [NR_SIGNALS-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic [3*NR_SIGNALS-1:0] store_mask_q, store_mask_d;
  logic [3*NR_SIGNALS-1:0] trig_mask_q, trig_mask_d;

  // Command stage
  logic                    cmd_vld_q, cmd_vld_d;
  logic [2:0]              cmd_q, cmd_d;

  // Capture control
  state_t                  state_q, state_d;
  logic [ADDR_BITS-1:0]    ptr_q, ptr_d;
  logic [ADDR_BITS-1:0]    post_cnt_q, post_cnt_d;
  logic [ADDR_BITS-1:0]    trig_addr_q, trig_addr_d;
  logic                    wrapped_q, wrapped_d;

  // RAM write port
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
  logic [NR_SIGNALS-1:0]   mem_wdata_q, mem_wdata_d;

  // Decoded commands; abort beats start, start beats force.
  logic cmd_abort, cmd_start, cmd_force;
  // Condition evaluation results for the sample currently in s1
  logic trig_hit, store_hit, store_any, store_used;
  // Write decision for this cycle
  logic do_write;

  always_comb begin
    cmd_abort = cmd_vld_q & cmd_q[1];
    cmd_start = cmd_vld_q & cmd_q[0] & ~cmd_q[1];
    cmd_force = cmd_vld_q & cmd_q[2] & ~cmd_q[1] & ~cmd_q[0];
  end

  // Trigger is an AND over all signals (don't-care codes pass). Store is an OR over
  // the signals that have a real code. An all-don't-care store mask stores every cycle.
  always_comb begin
    trig_hit   = 1'b1;
    store_any  = 1'b0;
    store_used = 1'b0;
    for (int i = 0; i < NR_SIGNALS; i++) begin
      trig_hit = trig_hit & cond_match(trig_mask_q[3*i +: 3], s1_q[i], s2_q[i]);
      if (cond_active(store_mask_q[3*i +: 3])) begin
        store_used = 1'b1;
        store_any  = store_any | cond_match(store_mask_q[3*i +: 3], s1_q[i], s2_q[i]);
      end
    end
    store_hit = store_any | ~store_used;
  end

  always_comb begin
    s1_d         = signals_in;
    s2_d         = s1_q;
    cmd_vld_d    = cmd_valid;
    cmd_d        = cmd_valid ? cmd : cmd_q;
    store_mask_d = store_mask_q;
    trig_mask_d  = trig_mask_q;
    state_d      = state_q;
    ptr_d        = ptr_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    wrapped_d    = wrapped_q;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    do_write     = 1'b0;

    if (cmd_abort) begin
      // The sample evaluated on the abort cycle is dropped. Pointer, trigger_addr
      // and wrapped keep their values so the capture can still be read back.
      state_d = ST_IDLE;
    end else if (cmd_start) begin
      state_d      = ST_ARMED;
      ptr_d        = '0;
      wrapped_d    = 1'b0;
      store_mask_d = store_mask;
      trig_mask_d  = trigger_mask;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (trig_hit || cmd_force) begin
            // The trigger sample is always stored, whatever the store condition says.
            do_write    = 1'b1;
            trig_addr_d = ptr_q;
            post_cnt_d  = post_trig_cnt;
            state_d     = (post_trig_cnt == '0) ? ST_DONE : ST_POST;
          end else if (store_hit) begin
            do_write = 1'b1;
          end
        end
        ST_POST: begin
          if (store_hit) begin
            do_write   = 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == {{(ADDR_BITS-1){1'b0}}, 1'b1}) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (do_write) begin
      mem_wr_d    = 1'b1;
      mem_addr_d  = ptr_q;
      mem_wdata_d = s1_q;
      // The final write of a capture does not advance the pointer. A full buffer
      // that ends exactly at the top address therefore does not report a wrap.
      if (state_d != ST_DONE) begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_BITS{1'b1}}) begin
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      s1_q         <= '0;
      s2_q         <= '0;
      store_mask_q <= '0;
      trig_mask_q  <= '0;
      cmd_vld_q    <= 1'b0;
      cmd_q        <= '0;
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      wrapped_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      store_mask_q <= store_mask_d;
      trig_mask_q  <= trig_mask_d;
      cmd_vld_q    <= cmd_vld_d;
      cmd_q        <= cmd_d;
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      wrapped_q    <= wrapped_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign state        = state_q;
  assign trigger_addr = trig_addr_q;
  assign wrapped      = wrapped_q;

endmodule

// File: tb/tb_icetap_capture.sv
// Bench for icetap_capture: condition-code vector table plus multi-cycle capture
// sequences. Expected RAM writes are queued when stimulus is driven and checked
// against the write port as writes appear.
module tb_icetap_capture;

  localparam int NS = 16;
  localparam int AB = 8;
  localparam logic [2:0] C_START = 3'b001;
  localparam logic [2:0] C_ABORT = 3'b010;
  localparam logic [2:0] C_FORCE = 3'b100;
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3;

  logic            clk = 1'b0;
  logic            reset_;
  logic [NS-1:0]   signals_in;
  logic [3*NS-1:0] store_mask;
  logic [3*NS-1:0] trigger_mask;
  logic [AB-1:0]   post_trig_cnt;
  logic [2:0]      cmd;
  logic            cmd_valid;
  logic            mem_wr;
  logic [AB-1:0]   mem_addr;
  logic [NS-1:0]   mem_wdata;
  logic [1:0]      state;
  logic [AB-1:0]   trigger_addr;
  logic            wrapped;

  icetap_capture #(.NR_SIGNALS(NS), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset_(reset_), .signals_in(signals_in), .store_mask(store_mask),
    .trigger_mask(trigger_mask), .post_trig_cnt(post_trig_cnt), .cmd(cmd),
    .cmd_valid(cmd_valid), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .state(state), .trigger_addr(trigger_addr), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AB-1:0] addr;
    logic [NS-1:0] data;
  } wr_t;

  typedef struct {
    logic [2:0] code;
    logic       prev;
    logic       cur;
    logic       exp_trig;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[14];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [NS-1:0] d);
    wr_t w;
    w.addr = AB'(a);
    w.data = d;
    sb.push_back(w);
  endtask

  // Called at a falling edge: apply inputs for one cycle, return at the next falling edge.
  task automatic drive(input logic [NS-1:0] sig, input logic cv, input logic [2:0] c);
    signals_in = sig;
    cmd_valid  = cv;
    cmd        = c;
    @(negedge clk);
  endtask

  // Write-port monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reset_ === 1'b0 && mem_wr === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    logic [3*NS-1:0] tm;
    logic [NS-1:0]   v;
    int              a;

    reset_ = 1'b0;
    signals_in = '0; store_mask = '0; trigger_mask = '0; post_trig_cnt = '0;
    cmd = '0; cmd_valid = 1'b0;
    #1 reset_ = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_trigger_addr", 32'(trigger_addr), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    reset_ = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(state), 32'(S_IDLE));

    // Condition code table: trigger = code on bit0 AND bit1 high; bit1 is high only
    // on the one sample under test. Store only on bit15, which stays low.
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'd1, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{3'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd2, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'd2, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd3, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{3'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{3'd4, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{3'd4, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{3'd5, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'd5, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{3'd6, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'd7, 1'b1, 1'b1, 1'b1};
    for (int r = 0; r < 14; r++) begin
      trigger_mask = '0;
      trigger_mask[2:0] = vecs[r].code;
      trigger_mask[5:3] = 3'd1;
      store_mask = '0;
      store_mask[47:45] = 3'd1;
      post_trig_cnt = '0;
      drive({15'b0, vecs[r].prev}, 1'b1, C_START);
      repeat (3) drive({15'b0, vecs[r].prev}, 1'b0, 3'b000);
      if (vecs[r].exp_trig) push(0, {14'b0, 1'b1, vecs[r].cur});
      drive({14'b0, 1'b1, vecs[r].cur}, 1'b0, 3'b000);
      repeat (4) drive({15'b0, vecs[r].cur}, 1'b0, 3'b000);
      check($sformatf("vec%0d_state", r), 32'(state), vecs[r].exp_trig ? 32'(S_DONE) : 32'(S_ARMED));
      if (vecs[r].exp_trig) check($sformatf("vec%0d_trig_addr", r), 32'(trigger_addr), 0);
    end

    // Counter: store odd values, trigger on exactly 0x1c00, four samples after it.
    tm = '0;
    for (int i = 0; i < NS; i++) tm[3*i +: 3] = (i >= 10 && i <= 12) ? 3'd1 : 3'd2;
    trigger_mask = tm;
    store_mask = 48'd1;
    post_trig_cnt = 8'd4;
    drive('0, 1'b1, C_START);
    a = 0;
    for (int k = 0; k < 32; k++) begin
      v = 16'h1bf0 + NS'(k);
      if ((v < 16'h1c00 && v[0]) || v == 16'h1c00 || (v > 16'h1c00 && v <= 16'h1c07 && v[0])) begin
        push(a, v);
        a++;
      end
      drive(v, 1'b0, 3'b000);
    end
    check("cnt_trig_addr", 32'(trigger_addr), 8);
    check("cnt_state", 32'(state), 32'(S_DONE));

    // All don't-care masks, full-depth post count.
    trigger_mask = '0; store_mask = '0; post_trig_cnt = 8'd255;
    drive('0, 1'b1, C_START);
    for (int k = 0; k < 260; k++) begin
      if (k <= 255) push(k, 16'h5000 + NS'(k));
      drive(16'h5000 + NS'(k), 1'b0, 3'b000);
    end
    check("full_state", 32'(state), 32'(S_DONE));
    check("full_wrapped", 32'(wrapped), 0);
    check("full_trig_addr", 32'(trigger_addr), 0);

    // Trigger never matches (bit0 rising AND bit1 falling with bits tied), store
    // every cycle, wrap, then force trigger on sample 300.
    trigger_mask = '0; trigger_mask[2:0] = 3'd3; trigger_mask[5:3] = 3'd4;
    store_mask = '0; post_trig_cnt = 8'd2;
    drive('0, 1'b1, C_START);
    for (int k = 0; k < 310; k++) begin
      v = {14'(k), 1'(k), 1'(k)};
      if (k == 100) check("nomatch_wrap_early", 32'(wrapped), 0);
      if (k == 256) check("nomatch_wrap_before", 32'(wrapped), 0);
      if (k == 257) check("nomatch_wrap_after", 32'(wrapped), 1);
      if (k <= 302) push(k, v);
      drive(v, k == 300, (k == 300) ? C_FORCE : 3'b000);
    end
    check("force_trig_addr", 32'(trigger_addr), 44);
    check("force_state", 32'(state), 32'(S_DONE));
    check("force_wrapped", 32'(wrapped), 1);

    // Start from DONE: pointer restarts at 0, wrapped cleared, new trigger on bit15.
    trigger_mask = '0; trigger_mask[47:45] = 3'd1;
    store_mask = '0; post_trig_cnt = 8'd1;
    drive('0, 1'b1, C_START);
    for (int k = 0; k < 10; k++) begin
      v = (k == 5) ? (16'h8000 | NS'(k)) : NS'(k);
      if (k == 2) check("restart_wrapped", 32'(wrapped), 0);
      if (k <= 6) push(k, v);
      drive(v, 1'b0, 3'b000);
    end
    check("restart_trig_addr", 32'(trigger_addr), 5);
    check("restart_state", 32'(state), 32'(S_DONE));

    // Abort and start together while ARMED after a wrap: abort wins.
    trigger_mask = '0; trigger_mask[2:0] = 3'd3; trigger_mask[5:3] = 3'd4;
    store_mask = '0; post_trig_cnt = 8'd3;
    drive('0, 1'b1, C_START);
    for (int k = 0; k < 270; k++) begin
      v = {14'(k), 1'(k), 1'(k)};
      if (k < 260) push(k, v);
      drive(v, k == 260, (k == 260) ? (C_ABORT | C_START) : 3'b000);
    end
    check("abort_state", 32'(state), 32'(S_IDLE));
    check("abort_wrapped", 32'(wrapped), 1);

    // Asynchronous reset in the middle of POST.
    trigger_mask = '0; trigger_mask[47:45] = 3'd1;
    store_mask = '0; post_trig_cnt = 8'd200;
    drive('0, 1'b1, C_START);
    for (int k = 0; k < 10; k++) begin
      v = (k == 3) ? (16'h8000 | NS'(k)) : NS'(k);
      if (k <= 8) push(k, v);
      drive(v, 1'b0, 3'b000);
    end
    check("prereset_state", 32'(state), 32'(S_POST));
    check("prereset_trig_addr", 32'(trigger_addr), 3);
    #2 reset_ = 1'b1;
    #1;
    check("arst_mem_wr", 32'(mem_wr), 0);
    check("arst_mem_addr", 32'(mem_addr), 0);
    check("arst_mem_wdata", 32'(mem_wdata), 0);
    check("arst_state", 32'(state), 32'(S_IDLE));
    check("arst_trigger_addr", 32'(trigger_addr), 0);
    check("arst_wrapped", 32'(wrapped), 0);
    sb.delete();
    @(negedge clk);
    reset_ = 1'b0;
    repeat (5) drive(16'hffff, 1'b0, 3'b000);
    check("post_release_state", 32'(state), 32'(S_IDLE));

    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
